// File: rtl/auto_player.sv
// auto_player: automatic responder for the game's buttons/lights interface (demo/self-test).
// Each lit mismatch bit is cleared by issuing one clean press/release pulse on the matching
// button line. Scanning repeats until the lights read zero or the press budget runs out.
//
// Ports:
//   i_clock         system clock
//   i_reset         synchronous, active-high reset
//   i_go            single-cycle start pulse, honoured only when idle
//   i_abort         return to idle with buttons released (no done/fail pulse)
//   i_lights        mismatch mask from the player; bit i high = button i must toggle
//   o_buttons       press pulses toward the player (at most one bit high)
//   o_busy          high whenever not idle
//   o_done          one-cycle pulse: lights read zero at a scan
//   o_fail          one-cycle pulse: budget exhausted with lights still nonzero
//   o_press_count   presses issued in the current/last run (saturates at 31)
module auto_player #(
  parameter int unsigned HOLD_CYCLES   = 6,
  parameter int unsigned GAP_CYCLES    = 3,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_PRESSES   = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_go,
  input  logic       i_abort,
  input  logic [7:0] i_lights,
  output logic [7:0] o_buttons,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [4:0] o_press_count
);

  localparam int unsigned MaxPhase =
      (HOLD_CYCLES > GAP_CYCLES) ?
      ((HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES) :
      ((GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES);
  // The counter is loaded with (length - 1) and counts down to zero.
  localparam int unsigned PhW = (MaxPhase <= 2) ? 1 : $clog2(MaxPhase);

  localparam logic [PhW-1:0] HoldLoad   = PhW'(HOLD_CYCLES - 1);
  localparam logic [PhW-1:0] GapLoad    = PhW'(GAP_CYCLES - 1);
  localparam logic [PhW-1:0] SettleLoad = PhW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]     MaxPress   = 5'(MAX_PRESSES);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StPress,
    StRelease,
    StSettle,
    StFinish
  } state_t;

  state_t         r_state;
  logic [PhW-1:0] r_phase;
  logic [2:0]     w_idx;

  // Lowest set bit wins: scan from the top so bit 0 is assigned last.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_lights[i]) w_idx = 3'(i);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_phase       <= '0;
      o_buttons     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_fail        <= 1'b0;
      o_press_count <= '0;
    end else begin
      o_done <= 1'b0;
      o_fail <= 1'b0;
      if (i_abort && (r_state != StIdle)) begin
        // press_count deliberately keeps its value for inspection after an abort.
        r_state   <= StIdle;
        r_phase   <= '0;
        o_buttons <= '0;
        o_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            o_buttons <= '0;
            if (i_go && !i_abort) begin
              o_press_count <= '0;
              o_busy        <= 1'b1;
              r_state       <= StScan;
            end
          end
          StScan: begin
            if (i_lights == 8'h00) begin
              o_done  <= 1'b1;
              r_state <= StFinish;
            end else if (o_press_count >= MaxPress) begin
              o_fail  <= 1'b1;
              r_state <= StFinish;
            end else begin
              // Button and count are registered here so both show on the first PRESS cycle.
              o_buttons <= 8'b1 << w_idx;
              if (o_press_count != 5'd31) o_press_count <= o_press_count + 5'd1;
              r_phase <= HoldLoad;
              r_state <= StPress;
            end
          end
          StPress: begin
            if (r_phase == '0) begin
              o_buttons <= '0;
              r_phase   <= GapLoad;
              r_state   <= StRelease;
            end else begin
              r_phase <= r_phase - 1'b1;
            end
          end
          StRelease: begin
            if (r_phase == '0) begin
              r_phase <= SettleLoad;
              r_state <= StSettle;
            end else begin
              r_phase <= r_phase - 1'b1;
            end
          end
          StSettle: begin
            if (r_phase == '0) begin
              r_state <= StScan;
            end else begin
              r_phase <= r_phase - 1'b1;
            end
          end
          StFinish: begin
            o_buttons <= '0;
            o_busy    <= 1'b0;
            r_state   <= StIdle;
          end
          default: begin
            o_buttons <= '0;
            o_busy    <= 1'b0;
            r_state   <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_player.sv
// Self-checking bench for auto_player. A registered player model (edge-toggle on presses,
// lights = code ^ state) closes the loop for the main instance; a second instance with
// MAX_PRESSES=4 sees lights stuck at 8'h80. Expected press indices are queued when each run
// is launched and popped as button rises are observed.
module tb_auto_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, go, abort, m_rst;
  logic [7:0] code, st, prev_b, lights;
  logic [7:0] buttons;
  logic       busy, done, fail;
  logic [4:0] pc;

  logic       go4, abort4;
  logic [7:0] lights4, buttons4;
  logic       busy4, done4, fail4;
  logic [4:0] pc4;

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];
  int done_cnt, fail_cnt, done4_cnt, fail4_cnt, pulses4;
  int hi, hi4, lo4;
  logic [7:0] pb, pb4;

  auto_player dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_go         (go),
    .i_abort      (abort),
    .i_lights     (lights),
    .o_buttons    (buttons),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_press_count(pc)
  );

  auto_player #(.MAX_PRESSES(4)) dut4 (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_go         (go4),
    .i_abort      (abort4),
    .i_lights     (lights4),
    .o_buttons    (buttons4),
    .o_busy       (busy4),
    .o_done       (done4),
    .o_fail       (fail4),
    .o_press_count(pc4)
  );

  // Player model: a rising press edge toggles that button's state; lights registered.
  always @(posedge clk) begin
    if (m_rst) begin
      st     <= 8'h00;
      prev_b <= 8'h00;
      lights <= code;
    end else begin
      prev_b <= buttons;
      st     <= st ^ (buttons & ~prev_b);
      lights <= code ^ st;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset(input logic [7:0] c);
    code  = c;
    m_rst = 1'b1;
    step(1);
    m_rst = 1'b0;
    step(1);
    done_cnt = 0;
    fail_cnt = 0;
  endtask

  // Leaves the bench observing the SCAN cycle that follows the go cycle.
  task automatic pulse_go();
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      step(1);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic wait_btn(input logic want_nz, input int limit);
    int k = 0;
    while (((buttons != 8'h00) !== want_nz) && k < limit) begin
      step(1);
      k++;
    end
    check("button_wait", buttons != 8'h00, want_nz);
  endtask

  // Main-instance monitor: one-hot presses, expected index order, hold length.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      hi = 0;
      pb = 8'h00;
    end else begin
      if (done) begin
        done_cnt++;
        check("done_fail_exclusive", fail, 0);
      end
      if (fail) fail_cnt++;
      if (buttons != 8'h00) begin
        check("buttons_onehot", $countones(buttons), 1);
        if (pb == 8'h00) begin
          check("press_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("press_idx", buttons, 32'd1 << e);
          end
          hi = 1;
        end else begin
          hi++;
        end
      end else if (pb != 8'h00 && busy) begin
        // Presses cut short by abort leave busy low and are not length-checked.
        check("hold_len", hi, 6);
      end
      pb = buttons;
    end
  end

  // Stuck-lights instance monitor: bit 7 only, 6 high, at least 5 low between presses.
  always @(negedge clk) begin
    if (rst) begin
      hi4 = 0;
      lo4 = 0;
      pb4 = 8'h00;
    end else begin
      if (done4) done4_cnt++;
      if (fail4) fail4_cnt++;
      if (buttons4 != 8'h00) begin
        check("stuck_bit7", buttons4, 8'h80);
        if (pb4 == 8'h00) begin
          pulses4++;
          if (pulses4 > 1) check("stuck_gap_ge5", lo4 >= 5, 1);
          hi4 = 1;
        end else begin
          hi4++;
        end
      end else begin
        if (pb4 != 8'h00) begin
          check("stuck_hold_len", hi4, 6);
          lo4 = 1;
        end else begin
          lo4++;
        end
      end
      pb4 = buttons4;
    end
  end

  initial begin
    int n;
    rst = 1'b1; m_rst = 1'b1; go = 1'b0; abort = 1'b0; go4 = 1'b0; abort4 = 1'b0;
    code = 8'h00; lights4 = 8'h80;
    done_cnt = 0; fail_cnt = 0; done4_cnt = 0; fail4_cnt = 0; pulses4 = 0;
    step(3);
    check("rst_buttons", buttons, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_pc", pc, 0);
    check("rst_buttons4", buttons4, 0);
    rst = 1'b0; m_rst = 1'b0;
    step(1);

    // Code 0000_0101: bit 0 then bit 2, done, two presses.
    model_reset(8'h05);
    q.push_back(0);
    q.push_back(2);
    pulse_go();
    check("t1_busy", busy, 1);
    check("t1_pc_cleared", pc, 0);
    wait_done(200, n);
    check("t1_pc", pc, 2);
    check("t1_lights_clear", lights, 0);
    step(1);
    check("t1_done_single", done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_queue_drained", q.size(), 0);
    check("t1_fail_cnt", fail_cnt, 0);
    check("t1_done_cnt", done_cnt, 1);

    // Lights already zero: done at go+2, no presses.
    model_reset(8'h00);
    pulse_go();
    check("t2_no_done_in_scan", done, 0);
    step(1);
    check("t2_done_go_plus_2", done, 1);
    check("t2_pc", pc, 0);
    step(1);
    check("t2_busy_low", busy, 0);
    check("t2_done_cnt", done_cnt, 1);

    // Stuck lights, budget 4: four bit-7 pulses then fail, never done.
    go4 = 1'b1;
    step(1);
    go4 = 1'b0;
    n = 0;
    while (!fail4 && n < 200) begin
      step(1);
      n++;
    end
    check("t3_fail", fail4, 1);
    check("t3_pulses", pulses4, 4);
    check("t3_pc", pc4, 4);
    step(2);
    check("t3_fail_cnt", fail4_cnt, 1);
    check("t3_done_cnt", done4_cnt, 0);
    check("t3_busy_low", busy4, 0);

    // Code FF: bits 0..7 in order; go cycle through done cycle inclusive = 2+8*12+1.
    model_reset(8'hFF);
    for (int i = 0; i < 8; i++) q.push_back(i);
    pulse_go();
    wait_done(300, n);
    check("t4_cycles", n + 2, 2 + 8 * 12 + 1);
    check("t4_pc", pc, 8);
    check("t4_lights_clear", lights, 0);
    check("t4_queue_drained", q.size(), 0);

    // Abort in the third PRESS cycle, then restart.
    model_reset(8'h03);
    q.push_back(0);
    pulse_go();
    wait_btn(1'b1, 10);
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t5_buttons_dropped", buttons, 0);
    check("t5_busy_low", busy, 0);
    check("t5_pc_held", pc, 1);
    step(3);
    check("t5_no_done", done_cnt, 0);
    check("t5_no_fail", fail_cnt, 0);
    model_reset(8'h03);
    q.push_back(0);
    q.push_back(1);
    pulse_go();
    check("t5_restart_pc", pc, 0);
    wait_done(200, n);
    check("t5_restart_final_pc", pc, 2);

    // Reset mid-RELEASE with go high: everything clears and go is ignored.
    model_reset(8'h01);
    q.push_back(0);
    pulse_go();
    wait_btn(1'b1, 10);
    wait_btn(1'b0, 20);
    step(1);
    rst = 1'b1;
    go  = 1'b1;
    step(1);
    rst = 1'b0;
    go  = 1'b0;
    check("t6_buttons", buttons, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_fail", fail, 0);
    check("t6_pc", pc, 0);
    step(1);
    check("t6_go_ignored", busy, 0);
    check("t6_still_released", buttons, 0);
    check("final_queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
